// File: rtl/approx_mult_pkg.sv
// Shared defaults, state encoding and helpers for the approximate-multiplier
// product accumulator.
package approx_mult_pkg;

    localparam int unsigned DEF_N  = 32;
    localparam int unsigned DEF_PW = 2 * DEF_N;
    localparam int unsigned DEF_GW = 8;
    localparam int unsigned DEF_AW = DEF_PW + DEF_GW;
    localparam int unsigned DEF_CW = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/approx_prod_accum.sv
// Frame accumulator for 64-bit multiplier products: sums beats up to in_last and
// presents sum, saturating beat count and sticky carry-out on a registered output.
module approx_prod_accum
    import approx_mult_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned PW = 2 * N,
    parameter int unsigned GW = DEF_GW,
    parameter int unsigned AW = PW + GW,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic [AW:0]   sum;
    logic [CW-1:0] cnt_next;
    logic          ovf_next;

    // Extra top bit of the sum is the carry-out of the AW-bit add.
    always_comb begin
        sum      = {1'b0, acc} + {{(GW + 1){1'b0}}, in_prod};
        cnt_next = CW'(sat_inc(32'(cnt), CNT_MAX));
        ovf_next = ovf | sum[AW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= sum[AW-1:0];
                        cnt <= cnt_next;
                        ovf <= ovf_next;
                        if (in_last) begin
                            out_acc   <= sum[AW-1:0];
                            out_count <= cnt_next;
                            out_ovf   <= ovf_next;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // out_acc/out_count/out_ovf intentionally keep their values.
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
